// File: rtl/rgb_step_sequencer_if.sv
`timescale 1ns/1ps
// Control/status bundle between the SPI register block and the RGB step sequencer.
interface rgb_step_sequencer_if #(
  parameter int SW = 3
);
  logic          i_wr_en;
  logic [SW+1:0] i_wr_addr;
  logic [7:0]    i_wr_data;
  logic [SW-1:0] i_last;
  logic          i_loop;
  logic [3:0]    i_speed;
  logic          i_start;
  logic          i_stop;
  logic [7:0]    o_r;
  logic [7:0]    o_g;
  logic [7:0]    o_b;
  logic          o_busy;
  logic [SW-1:0] o_step;
  logic          o_done;

  // Register block side: drives table writes and playback controls.
  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_last, i_loop, i_speed, i_start, i_stop,
    input  o_r, o_g, o_b, o_busy, o_step, o_done
  );

  // Sequencer side.
  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_last, i_loop, i_speed, i_start, i_stop,
    output o_r, o_g, o_b, o_busy, o_step, o_done
  );
endinterface

// File: rtl/rgb_step_sequencer.sv
`timescale 1ns/1ps
// RGB step sequencer: plays a table of colour steps, slewing each channel by
// one LSB per tick toward the step target, then holding for HOLD+1 ticks.
// Outputs only ever move by +/-1, so the downstream LED drivers never see a jump.
module rgb_step_sequencer #(
  parameter int STEPS = 8,
  parameter int SW    = 3
) (
  input logic                 clk,
  input logic                 rst,
  rgb_step_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, FADE, HOLD} state_t;

  state_t        state_reg;
  logic [7:0]    r_reg, g_reg, b_reg;
  logic [7:0]    tr_reg, tg_reg, tb_reg;
  logic [7:0]    hold_reg;
  logic [SW-1:0] step_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [15:0]   tick_cnt_reg;

  logic [7:0]    rd_r, rd_g, rd_b, rd_h;
  logic [15:0]   tick_term;
  logic          tick;
  logic          at_target;
  logic          at_last;
  logic [SW-1:0] step_inc;

  // Step table: one byte-wide RAM per field (0=R, 1=G, 2=B, 3=HOLD). The read
  // address is always the loaded step; a colliding write returns the old byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      logic [7:0] mem [STEPS];
      logic [7:0] rd_q;

      // Synchronous write of the addressed field, registered read of the current step.
      always_ff @(posedge clk) begin
        if (bus.i_wr_en && (bus.i_wr_addr[1:0] == 2'(gi))) begin
          mem[bus.i_wr_addr[SW+1:2]] <= bus.i_wr_data;
        end
        rd_q <= mem[step_reg];
      end
    end
  endgenerate

  assign rd_r = g_field[0].rd_q;
  assign rd_g = g_field[1].rd_q;
  assign rd_b = g_field[2].rd_q;
  assign rd_h = g_field[3].rd_q;

  // Terminal count follows i_speed live; an equality compare means a count
  // already past a newly lowered terminal simply wraps round without a tick.
  assign tick_term = 16'((17'd1 << bus.i_speed) - 17'd1);
  assign tick      = busy_reg && (tick_cnt_reg == tick_term);

  assign at_target = (r_reg == tr_reg) && (g_reg == tg_reg) && (b_reg == tb_reg);
  assign at_last   = (step_reg == bus.i_last);
  assign step_inc  = SW'(step_reg + 1'b1);

  // Move one LSB toward the target; equal channels stay put, so no wrap at 0/255.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end
    return cur;
  endfunction

  // Tick prescaler: free-runs while busy, restarts on every start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_reg <= 16'd0;
    end else if ((state_reg == IDLE) || bus.i_start) begin
      tick_cnt_reg <= 16'd0;
    end else if (tick) begin
      tick_cnt_reg <= 16'd0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 16'd1;
    end
  end

  // Playback FSM with registered colour, step, busy and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      r_reg     <= 8'd0;
      g_reg     <= 8'd0;
      b_reg     <= 8'd0;
      tr_reg    <= 8'd0;
      tg_reg    <= 8'd0;
      tb_reg    <= 8'd0;
      hold_reg  <= 8'd0;
      step_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.i_stop) begin
        // Stop freezes the colour where it is and never reports completion.
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else if (bus.i_start) begin
        // (Re)start from step 0 without clearing the colour: the fade starts from here.
        state_reg <= LOAD0;
        busy_reg  <= 1'b1;
        step_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            busy_reg <= 1'b0;
          end
          LOAD0: begin
            // RAM is reading step_reg this cycle.
            state_reg <= LOAD1;
          end
          LOAD1: begin
            tr_reg    <= rd_r;
            tg_reg    <= rd_g;
            tb_reg    <= rd_b;
            hold_reg  <= rd_h;
            state_reg <= FADE;
          end
          FADE: begin
            if (tick) begin
              if (at_target) begin
                state_reg <= HOLD;
              end else begin
                r_reg <= slew(r_reg, tr_reg);
                g_reg <= slew(g_reg, tg_reg);
                b_reg <= slew(b_reg, tb_reg);
              end
            end
          end
          HOLD: begin
            if (tick) begin
              if (hold_reg != 8'd0) begin
                hold_reg <= hold_reg - 8'd1;
              end else if (!at_last) begin
                // Also covers a step beyond a lowered i_last: wraps modulo STEPS.
                step_reg  <= step_inc;
                state_reg <= LOAD0;
              end else if (bus.i_loop) begin
                step_reg  <= '0;
                state_reg <= LOAD0;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_r    = r_reg;
  assign bus.o_g    = g_reg;
  assign bus.o_b    = b_reg;
  assign bus.o_busy = busy_reg;
  assign bus.o_step = step_reg;
  assign bus.o_done = done_reg;

endmodule

// File: tb/tb_rgb_step_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for rgb_step_sequencer: per-cycle trace comparison
// against a step-level timing model, plus directed stop/restart/reset cases.
module tb_rgb_step_sequencer;
  localparam int STEPS = 8;
  localparam int SW    = 3;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] step;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_step_sequencer_if #(.SW(SW)) bus();

  rgb_step_sequencer #(.STEPS(STEPS), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   m_r [STEPS];
  int   m_g [STEPS];
  int   m_b [STEPS];
  int   m_h [STEPS];
  obs_t exp_q [$];
  int   play_start [64];
  int   cur_r, cur_g, cur_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t mk(input bit busy, input bit done, input int s,
                              input int r, input int g, input int b);
    obs_t e;
    e.busy = busy;
    e.done = done;
    e.step = 3'(s);
    e.r    = 8'(r);
    e.g    = 8'(g);
    e.b    = 8'(b);
    return e;
  endfunction

  function automatic obs_t obs_now();
    return mk(bus.o_busy, bus.o_done, int'(bus.o_step), int'(bus.o_r), int'(bus.o_g), int'(bus.o_b));
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Colour value k slew ticks after leaving c on the way to t.
  function automatic int toward(input int c, input int t, input int k);
    if (t >= c) return (c + k < t) ? c + k : t;
    return (c - k > t) ? c - k : t;
  endfunction

  function automatic int maxdiff(input int cr, input int cg, input int cb, input int s);
    int d;
    d = iabs(m_r[s] - cr);
    if (iabs(m_g[s] - cg) > d) d = iabs(m_g[s] - cg);
    if (iabs(m_b[s] - cb) > d) d = iabs(m_b[s] - cb);
    return d;
  endfunction

  // Expected per-clock view after the start edge, at tick-every-clock speed:
  // 2 load clocks, D+1 fade clocks, HOLD+1 hold clocks, then next step or done.
  task automatic build_trace(input int r0, input int g0, input int b0, input int last_a,
                             input int last_b, input bit lp, input int max_plays);
    int s, lst, d, cr, cg, cb, plays;
    exp_q.delete();
    s = 0; plays = 0; cr = r0; cg = g0; cb = b0;
    while (plays < max_plays) begin
      play_start[plays] = exp_q.size();
      lst = (plays == 0) ? last_a : last_b;
      exp_q.push_back(mk(1, 0, s, cr, cg, cb));
      exp_q.push_back(mk(1, 0, s, cr, cg, cb));
      d = maxdiff(cr, cg, cb, s);
      for (int k = 0; k <= d; k++)
        exp_q.push_back(mk(1, 0, s, toward(cr, m_r[s], k), toward(cg, m_g[s], k), toward(cb, m_b[s], k)));
      cr = m_r[s]; cg = m_g[s]; cb = m_b[s];
      for (int k = 0; k <= m_h[s]; k++) exp_q.push_back(mk(1, 0, s, cr, cg, cb));
      plays++;
      if (s == lst && !lp) begin
        exp_q.push_back(mk(0, 1, s, cr, cg, cb));
        break;
      end
      s = (s == lst) ? 0 : (s + 1) % STEPS;
    end
  endtask

  task automatic set_cur();
    cur_r = int'(exp_q[$].r);
    cur_g = int'(exp_q[$].g);
    cur_b = int'(exp_q[$].b);
  endtask

  task automatic wr(input int s, input int f, input int v);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = {3'(s), 2'(f)};
    bus.i_wr_data = 8'(v);
    @(posedge clk); #1;
    bus.i_wr_en = 1'b0;
    case (f)
      0: m_r[s] = v;
      1: m_g[s] = v;
      2: m_b[s] = v;
      default: m_h[s] = v;
    endcase
  endtask

  task automatic wr_step(input int s, input int r, input int g, input int b, input int h);
    wr(s, 0, r); wr(s, 1, g); wr(s, 2, b); wr(s, 3, h);
  endtask

  // Pulse start, then compare n_obs clocks against exp_q. wr_at=-1 writes with
  // the start pulse, wr_at>=0 writes after that observation; last_at changes i_last.
  task automatic run_trace(input string name, input int n_obs, input int wr_at,
                           input logic [4:0] wa, input logic [7:0] wd,
                           input int last_at, input logic [2:0] new_last);
    int n;
    n = (n_obs < 0 || n_obs > exp_q.size()) ? exp_q.size() : n_obs;
    bus.i_start = 1'b1;
    if (wr_at == -1) begin
      bus.i_wr_en = 1'b1; bus.i_wr_addr = wa; bus.i_wr_data = wd;
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_wr_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus.i_wr_en = 1'b0;
      chk($sformatf("%s[%0d]", name, k), 32'(obs_now()), 32'(exp_q[k]));
      if (k == wr_at) begin
        bus.i_wr_en = 1'b1; bus.i_wr_addr = wa; bus.i_wr_data = wd;
      end
      if (k == last_at) bus.i_last = new_last;
    end
    bus.i_wr_en = 1'b0;
    $display("trace %s: %0d cycles compared", name, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, nchg, lst, n;
    int t_chg [8];
    logic [7:0] prev_r;

    bus.i_wr_en = 0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_last = '0;
    bus.i_loop = 0; bus.i_speed = '0; bus.i_start = 0; bus.i_stop = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'(obs_now()), 32'(mk(0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_idle", 32'(obs_now()), 32'(mk(0, 0, 0, 0, 0, 0)));
    cur_r = 0; cur_g = 0; cur_b = 0;

    // One-shot, HOLD rewritten in the same cycle as start.
    wr_step(0, 3, 0, 0, 9);
    bus.i_last = 3'd0; bus.i_loop = 1'b0; bus.i_speed = 4'd0;
    m_h[0] = 2;
    build_trace(cur_r, cur_g, cur_b, 0, 0, 0, 64);
    run_trace("oneshot", -1, -1, {3'd0, 2'd3}, 8'd2, -2, 3'd0);
    @(posedge clk); #1;
    chk("oneshot_after", 32'(obs_now()), 32'(mk(0, 0, 0, 3, 0, 0)));
    set_cur();

    // Looped two-step crossfade, then stop.
    wr_step(0, 255, 0, 0, 0);
    wr_step(1, 0, 255, 0, 0);
    bus.i_last = 3'd1; bus.i_loop = 1'b1;
    build_trace(cur_r, cur_g, cur_b, 1, 1, 1, 4);
    run_trace("loop", -1, -2, '0, '0, -2, 3'd0);
    bus.i_stop = 1'b1;
    @(posedge clk); #1;
    bus.i_stop = 1'b0;
    chk("loop_stop", 32'(obs_now()), 32'(mk(0, 0, 1, 0, 255, 0)));
    @(posedge clk); #1;
    chk("loop_stop_frozen", 32'(obs_now()), 32'(mk(0, 0, 1, 0, 255, 0)));
    cur_r = 0; cur_g = 255; cur_b = 0;

    // Stop mid-fade at r=100, then restart and resume from the frozen colour.
    wr_step(0, 200, 0, 0, 0);
    bus.i_last = 3'd0; bus.i_loop = 1'b0;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      if (bus.o_r == 8'd100) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("stop_wait", 32'(found), 32'd1);
    bus.i_stop = 1'b1;
    @(posedge clk); #1;
    bus.i_stop = 1'b0;
    chk("stop_mid_fade", 32'(obs_now()), 32'(mk(0, 0, 0, 100, 155, 0)));
    @(posedge clk); #1;
    chk("stop_frozen", 32'(obs_now()), 32'(mk(0, 0, 0, 100, 155, 0)));
    build_trace(100, 155, 0, 0, 0, 0, 64);
    run_trace("resume", -1, -2, '0, '0, -2, 3'd0);
    set_cur();

    // Start and stop together in IDLE: stop wins.
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("start_stop[%0d]", k), 32'(obs_now()), 32'(mk(0, 0, 0, 200, 0, 0)));
      @(posedge clk); #1;
    end

    // Slow ticks: output changes spaced 2^4 clocks apart.
    wr_step(0, 205, 0, 0, 0);
    bus.i_speed = 4'd4;
    prev_r = 8'(cur_r);
    nchg = 0;
    for (int i = 0; i < 8; i++) t_chg[i] = 0;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.o_r !== prev_r) begin
        if (nchg < 8) t_chg[nchg] = c;
        nchg++;
        prev_r = bus.o_r;
      end
      if (!bus.o_busy) break;
      @(posedge clk); #1;
    end
    chk("speed_changes", 32'(nchg), 32'd5);
    for (int i = 1; i < 5; i++)
      chk($sformatf("speed_gap%0d", i), 32'(t_chg[i] - t_chg[i-1]), 32'd16);
    chk("speed_end", 32'(obs_now()), 32'(mk(0, 1, 0, 205, 0, 0)));
    $display("speed test: %0d changes", nchg);
    bus.i_speed = 4'd0;
    cur_r = 205; cur_g = 0; cur_b = 0;

    // Random tables and last-step index, one-shot.
    for (int run = 0; run < 3; run++) begin
      for (int s = 0; s < STEPS; s++)
        wr_step(s, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
      lst = $urandom_range(0, STEPS - 1);
      bus.i_last = 3'(lst);
      build_trace(cur_r, cur_g, cur_b, lst, lst, 0, 64);
      run_trace($sformatf("rand%0d", run), -1, -2, '0, '0, -2, 3'd0);
      set_cur();
    end

    // Rewrite step 1 R while step 0 plays; lower i_last to 0 during step 1.
    wr_step(0, 20, 20, 20, 3);
    wr_step(1, 5, 0, 0, 4);
    for (int s = 2; s < STEPS; s++)
      wr_step(s, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 3));
    bus.i_last = 3'd1;
    m_r[1] = 40;
    build_trace(cur_r, cur_g, cur_b, 1, 0, 0, 64);
    run_trace("rewrite", -1, 1, {3'd1, 2'd0}, 8'd40, play_start[1] + 3, 3'd0);
    set_cur();

    // Asynchronous reset during HOLD.
    wr_step(0, 50, 60, 70, 20);
    bus.i_last = 3'd0;
    build_trace(cur_r, cur_g, cur_b, 0, 0, 0, 64);
    n = 2 + maxdiff(cur_r, cur_g, cur_b, 0) + 1 + 5;
    run_trace("arst", n, -2, '0, '0, -2, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_now", 32'(obs_now()), 32'(mk(0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_held", 32'(obs_now()), 32'(mk(0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    chk("arst_release", 32'(obs_now()), 32'(mk(0, 0, 0, 0, 0, 0)));

    // Table survives reset.
    build_trace(0, 0, 0, 0, 0, 0, 64);
    run_trace("retained", -1, -2, '0, '0, -2, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_step_sequencer.md
Name: rgb_step_sequencer

Overview:
Plays a programmable table of RGB colour steps and drives three 8-bit brightness values into the per-channel delta-sigma LED drivers. Each step slews all three channels toward a target colour, one LSB per tick, then holds it for a programmed number of ticks. The table and controls are written from the SPI register block. The sequencer supports one-shot and looped playback, stop, and restart.

Parameters:
STEPS, 8, table depth in entries (power of 2, 2..16)
SW, 3, step index width = log2(STEPS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_wr_en  in  1  table write strobe, one entry field per cycle
i_wr_addr  in  SW+2  {step index, field}; field 0=R, 1=G, 2=B, 3=HOLD
i_wr_data  in  8  field value
i_last  in  SW  index of last step played
i_loop  in  1  1: wrap to step 0 after last step; 0: stop after last step
i_speed  in  4  tick period = 2^i_speed clocks
i_start  in  1  start/restart pulse
i_stop  in  1  stop pulse
o_r, o_g, o_b  out  8 each  current brightness
o_busy  out  1  high in any state except IDLE
o_step  out  SW  step currently loaded
o_done  out  1  one-cycle pulse when a one-shot sequence completes

Behaviour:
- Reset (async, rst=1): state IDLE; o_r/o_g/o_b=0; o_step=0; o_busy=0; o_done=0; tick counter=0. Table contents are not reset.
- Table: STEPS x 4 x 8-bit entries, synchronous write.
  - A write in the same cycle as a read of the same entry returns the old data.
  - Writes are allowed at any time; a change takes effect the next time that step is loaded.
- Tick generator:
  - 16-bit counter, cleared in IDLE and on i_start.
  - Counts while o_busy=1; a tick fires when count == 2^i_speed - 1, then the counter clears.
  - i_speed=0 gives a tick every cycle.
  - i_speed is sampled live; if the count already exceeds the new terminal value, the counter runs on and wraps (no spurious tick).
- States: IDLE, LOAD0, LOAD1, FADE, HOLD.
  - IDLE: on i_start -> LOAD0 with o_step=0.
  - LOAD0: presents read address o_step (1 cycle) -> LOAD1.
  - LOAD1: latches target R/G/B and hold_cnt=HOLD (1 cycle) -> FADE.
  - FADE: on each tick, if all three outputs equal their targets -> HOLD. Otherwise each unequal channel moves +1 or -1 toward its target, independently.
  - FADE duration: max|target-current| + 1 ticks, including the equality-check tick.
  - HOLD: on each tick, if hold_cnt==0, advance; otherwise decrement. HOLD therefore lasts HOLD+1 ticks.
  - Advance, o_step != i_last: o_step+1 -> LOAD0.
  - Advance, o_step == i_last and i_loop=1: o_step=0 -> LOAD0.
  - Advance, o_step == i_last and i_loop=0: -> IDLE; o_done=1 for that cycle; outputs keep the final colour.
- o_step greater than i_last (i_last lowered mid-run): advancing wraps modulo STEPS until o_step == i_last.
- Outputs never jump; they change only by +/-1 per tick in FADE, so brightness is glitch-free.
- i_stop in any state: -> IDLE next cycle; outputs frozen; no o_done.
- i_start while busy: restart at LOAD0, step 0; outputs are not cleared, so the first step fades from the current colour.
- i_start and i_stop in the same cycle: i_stop wins.
- Write and start in the same cycle: the write completes; step 0 is loaded with the new data if that entry was written.
- Arithmetic: slewing saturates inherently at the target, so there is no over/underflow at 0 or 255.

Test Plan:
- i_speed=0, step0={R=3,G=0,B=0,HOLD=2}, i_last=0, i_loop=0, pulse i_start:
  - o_busy rises the next cycle.
  - After 2 LOAD cycles, o_r = 1, 2, 3 on consecutive cycles.
  - One equality tick, then 3 HOLD ticks.
  - o_done pulses once, o_busy falls in the same cycle, o_r stays 3.
- Two steps {255,0,0,H0} and {0,255,0,H0}, i_loop=1, i_speed=0:
  - o_r ramps 255 down to 0 while o_g ramps 0 up to 255 simultaneously.
  - After step 1, o_step returns to 0; o_done is never asserted.
- i_speed=4: successive output changes during FADE are exactly 16 clocks apart.
- i_stop mid-FADE with o_r=100: state IDLE next cycle, o_r holds 100, o_done=0. Then i_start: fade resumes from 100 toward the step-0 target.
- Simultaneous i_start and i_stop in IDLE -> stays IDLE. rst asserted mid-HOLD -> all outputs 0 immediately (asynchronous), without waiting for a clock edge.
- Rewrite step1 R while step 0 is playing: the new value is used when step 1 is loaded. Lowering i_last to 0 mid-step1 with STEPS=8 -> o_step wraps through 2..7 and then ends at 0.
